// File: rtl/cclimb_pkg.sv
// Shared types and default sizing for the Crazy Climber core.
// The ROM loader and its neighbours import these so the sizes agree.
package cclimb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2,
      ST_RUN  = 2'd3
   } load_state_t;

   localparam logic [16:0] ROM_SIZE_DEF = 17'h10000;
   localparam logic [15:0] HOLDOFF_DEF  = 16'd1024;

endpackage

// File: rtl/cclimb_rom_loader.sv
// Bridges the HPS ioctl download into the core ROM write port, validates
// ordering and length, and keeps the core in reset until the image settles.
module cclimb_rom_loader
   import cclimb_pkg::*;
#(
   parameter logic [16:0] ROM_SIZE = ROM_SIZE_DEF,
   parameter logic [15:0] HOLDOFF  = HOLDOFF_DEF
)
(
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic        core_reset,
   output logic        rom_ready,
   output logic        load_err,
   output logic [7:0]  checksum
);

   load_state_t state_r;
   logic        dl_prev_r;
   logic [16:0] byte_cnt_r;
   logic [15:0] hold_cnt_r;

   logic dl_rise_s;
   logic dl_fall_s;
   logic addr_in_rom_s;
   logic addr_in_seq_s;

   assign dl_rise_s     = ioctl_download & ~dl_prev_r;
   assign dl_fall_s     = ~ioctl_download & dl_prev_r;
   assign addr_in_rom_s = (ioctl_addr < {8'd0, ROM_SIZE});
   assign addr_in_seq_s = (ioctl_addr == {8'd0, byte_cnt_r});

   // Loader state machine with all outputs registered.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         // Track the live level so a download held high across reset is not a new edge.
         dl_prev_r  <= ioctl_download;
         byte_cnt_r <= 17'd0;
         hold_cnt_r <= 16'd0;
         dn_wr      <= 1'b0;
         dn_addr    <= 16'd0;
         dn_data    <= 8'd0;
         core_reset <= 1'b1;
         rom_ready  <= 1'b0;
         load_err   <= 1'b0;
         checksum   <= 8'd0;
      end else begin
         dl_prev_r <= ioctl_download;
         dn_wr     <= 1'b0;
         if (dl_rise_s && (state_r != ST_LOAD)) begin
            state_r    <= ST_LOAD;
            byte_cnt_r <= 17'd0;
            hold_cnt_r <= 16'd0;
            checksum   <= 8'd0;
            load_err   <= 1'b0;
            core_reset <= 1'b1;
            rom_ready  <= 1'b0;
         end else begin
            case (state_r)
               ST_LOAD: begin
                  if (dl_fall_s) begin
                     state_r    <= ST_HOLD;
                     hold_cnt_r <= HOLDOFF;
                     if (byte_cnt_r != ROM_SIZE) begin
                        load_err <= 1'b1;
                     end else begin
                        load_err <= load_err;
                     end
                  end else if (ioctl_wr) begin
                     if (addr_in_rom_s && addr_in_seq_s) begin
                        byte_cnt_r <= byte_cnt_r + 17'd1;
                        dn_wr      <= 1'b1;
                        dn_addr    <= ioctl_addr[15:0];
                        dn_data    <= ioctl_dout;
                        checksum   <= checksum ^ ioctl_dout;
                     end else begin
                        load_err <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end
               ST_HOLD: begin
                  if (hold_cnt_r != 16'd0) begin
                     hold_cnt_r <= hold_cnt_r - 16'd1;
                  end else begin
                     state_r    <= ST_RUN;
                     core_reset <= 1'b0;
                     rom_ready  <= ~load_err;
                  end
               end
               ST_IDLE: begin
                  core_reset <= 1'b1;
                  rom_ready  <= 1'b0;
               end
               ST_RUN: begin
                  core_reset <= 1'b0;
                  rom_ready  <= ~load_err;
               end
               default: begin
                  state_r    <= ST_IDLE;
                  core_reset <= 1'b1;
                  rom_ready  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
